copper_bands: RTL and testbench
===============================

# copper_bands

Programmable multi-band copper for the video pipeline. It produces one 24-bit background colour per scanline from a table of `N_BANDS` gradient bands. Each band has its own start line, base colour, signed per-channel increment and step length. A config bridge writes the table into a shadow copy; the shadow is committed to the active table only at frame start, so there is no tearing. The block runs on the pixel clock, with hsync/vsync supplied as one-cycle strobes; its output feeds the pixel mixer as background.

## Interface
- `COORD_WIDTH`, 16: width of signed `y`.
- `N_BANDS`, 4: table entries, power of two, ≥2.
- `STEP_WIDTH`, 8: width of lines-per-step field.
- `BACKGROUND`, 24'h000000: colour before first band / after reset.
- `clk` in 1: pixel clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `hsync` in 1: one-cycle strobe, once per line.
- `vsync` in 1: one-cycle strobe, once per frame.
- `y` in COORD_WIDTH signed: line about to be displayed, valid on `hsync`.
- `cfg_wr` in 1: write strobe to shadow table, always accepted.
- `cfg_addr` in $clog2(N_BANDS)+2: {band, field}.
- `cfg_data` in 32: write data.
- `cfg_commit` in 1: request shadow→active copy at next vsync.
- `color_rgb` out 24: current line colour.
- `band_active` out 1: a band is in effect.
- `commit_pending` out 1: commit requested, not yet applied.

## Operation
- Fields: 0 = start_y (`cfg_data[COORD_WIDTH-1:0]`, signed); 1 = base colour [23:0]; 2 = increment, three signed 8-bit deltas R[23:16] G[15:8] B[7:0]; 3 = {enable [31], lines_per_step [STEP_WIDTH-1:0]}.
- Active-table reset values:
  - start_y = 0, base = `BACKGROUND`, inc = 0, lines_per_step = 1.
  - enable = 0 for all bands.
  - Shadow table has the same reset values.
- State: `next_idx` (0..N_BANDS), `cur` band registers, `line_ctr` (STEP_WIDTH).
- On `vsync`:
  - If `commit_pending` or `cfg_commit`, copy shadow to active and clear `commit_pending`.
  - Set `next_idx`=0, `color_rgb`=`BACKGROUND`, `band_active`=0, `line_ctr`=0.
- On `hsync`, with priority top-down:
  - Band load: if `next_idx`<N_BANDS, the band at `next_idx` is enabled, and `y` == its start_y, then load base colour, latch inc/step, set `line_ctr`=0, `next_idx`++, `band_active`=1.
  - Step: else if `band_active`, increment `line_ctr`. When `line_ctr` == max(lines_per_step,1)−1, set `line_ctr`=0 and add inc to each channel.
  - Otherwise: no change.
- Channel add is signed delta on an unsigned 8-bit channel, saturating to [0,255]. Channels are independent; there is no carry between them.
- A disabled band terminates the list; later bands are never reached in that frame.
- Bands must have ascending start_y. Out-of-order bands are simply never matched, and the frame stays in the previous band.
- Only band `next_idx` is compared. There is no search.
- `cfg_commit` while pending: no effect (still one copy).

## Timing
- `color_rgb`, `band_active` and `commit_pending` update 1 clk after the qualifying strobe, and are registered.
- `vsync` and `hsync` in the same cycle: the vsync actions apply first. The hsync then evaluates with `next_idx`=0 against the newly committed table, and a match loads band 0 in that same update.
- `cfg_wr` in the same cycle as the commit copy: the active table gets the pre-write shadow value. The write lands in the shadow and needs a further commit.
- `cfg_commit` and `vsync` in the same cycle: the copy happens at that vsync, and `commit_pending` stays 0.
- Reset mid-frame:
  - All outputs are forced to their reset values in the next clk: `color_rgb`=`BACKGROUND`, `band_active`=0, `commit_pending`=0.
  - Both tables revert.
  - The block stays in `BACKGROUND` until a band matches after the next vsync or hsync.
- Strobes with no match change nothing. `color_rgb` holds between strobes.

## Structure
- `copper_pkg`:
  - `band_t` struct (start_y, base, inc, enable, step).
  - `field_e` enum (FLD_START, FLD_BASE, FLD_INC, FLD_CTRL).
  - `sat_add8(u8, s8)` function.
  - `rgb_step(rgb, inc)` function.
- Sub-module `copper_band_table`:
  - Shadow and active arrays, write decode, commit copy.
  - Exposes a read port selected by `next_idx`.
- Top level holds the line sequencer and the colour arithmetic.

## Test plan
- Reset, then vsync and 200 hsync with no config → `color_rgb`=000000 and `band_active`=0 throughout; `cfg_commit` without vsync changes nothing.
- Band 0 configured (start 10, base 102030, inc +1/+2/+3, step 2, en), then commit and vsync → lines <10 are 000000; line 10 is 102030; line 12 is 112233; line 14 is 122436.
- Band 0 base FEFE01, inc +2/−1/−3, step 1 → next line FFFD00, then FFFC00 (saturation per channel, no carry).
- Band 0 at start 5, band 1 at start 20 (base 445566), band 2 disabled, band 3 at start 30 → line 20 switches to 445566; line 30 shows no change.
- Shadow write of band 0 base mid-frame without commit → no change until commit and vsync; the new base appears from the next frame's line 10.
- vsync, hsync and `cfg_commit` in the same cycle with `y`=start_y of new band 0 → the new band-0 base appears 1 clk later, and `commit_pending` stays 0.

Source files
------------

// File: rtl/copper_pkg.sv
// Shared types and per-channel colour arithmetic for the copper band generator.
package copper_pkg;

  typedef enum logic [1:0] {
    FLD_START = 2'd0,
    FLD_BASE  = 2'd1,
    FLD_INC   = 2'd2,
    FLD_CTRL  = 2'd3
  } field_e;

  // Coordinate and step fields are held at 32 bits so the struct is
  // independent of the instance parameters; unused upper bits are constant.
  typedef struct packed {
    logic signed [31:0] start_y;
    logic [23:0]        base;
    logic [23:0]        inc;
    logic               enable;
    logic [31:0]        step;
  } band_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] u8, input logic signed [7:0] s8);
    logic signed [9:0] sum;
    sum = $signed({2'b00, u8}) + 10'(s8);
    if (sum < 10'sd0) return 8'h00;
    if (sum > 10'sd255) return 8'hFF;
    return sum[7:0];
  endfunction

  function automatic logic [23:0] rgb_step(input logic [23:0] rgb, input logic [23:0] inc);
    return {sat_add8(rgb[23:16], inc[23:16]),
            sat_add8(rgb[15:8],  inc[15:8]),
            sat_add8(rgb[7:0],   inc[7:0])};
  endfunction

endpackage

// File: rtl/copper_band_table.sv
// Shadow/active band tables: config writes land in the shadow, a copy
// request moves the whole shadow into the active table in one cycle.
module copper_band_table
  import copper_pkg::*;
#(
  parameter int          COORD_WIDTH = 16,
  parameter int          N_BANDS     = 4,
  parameter int          STEP_WIDTH  = 8,
  parameter logic [23:0] BACKGROUND  = 24'h000000
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         i_wr,
  input  logic [$clog2(N_BANDS)+1:0]   i_addr,
  input  logic [31:0]                  i_data,
  input  logic                         i_copy,
  input  logic [$clog2(N_BANDS)-1:0]   i_rd_idx,
  input  logic                         i_rd_shadow,
  output band_t                        o_band
);
  localparam int IDX_W = $clog2(N_BANDS);
  localparam band_t RST_BAND = '{start_y: 32'sd0, base: BACKGROUND, inc: 24'h0,
                                 enable: 1'b0, step: 32'd1};

  band_t r_shadow [N_BANDS];
  band_t r_active [N_BANDS];

  field_e                         w_field;
  logic [IDX_W-1:0]               w_band;
  logic signed [COORD_WIDTH-1:0]  w_start;
  logic                           w_unused_data;

  assign w_field       = field_e'(i_addr[1:0]);
  assign w_band        = i_addr[IDX_W+1:2];
  assign w_start       = i_data[COORD_WIDTH-1:0];
  assign w_unused_data = ^i_data;

  // Copy samples the shadow before any same-cycle write lands in it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BANDS; i++) begin
        r_shadow[i] <= RST_BAND;
        r_active[i] <= RST_BAND;
      end
    end else begin
      if (i_copy) r_active <= r_shadow;
      if (i_wr) begin
        case (w_field)
          FLD_START: r_shadow[w_band].start_y <= 32'(w_start);
          FLD_BASE:  r_shadow[w_band].base    <= i_data[23:0];
          FLD_INC:   r_shadow[w_band].inc     <= i_data[23:0];
          FLD_CTRL: begin
            r_shadow[w_band].enable <= i_data[31];
            r_shadow[w_band].step   <= 32'(i_data[STEP_WIDTH-1:0]);
          end
        endcase
      end
    end
  end

  assign o_band = i_rd_shadow ? r_shadow[i_rd_idx] : r_active[i_rd_idx];

endmodule

// File: rtl/copper_bands.sv
// Per-scanline background colour from a committed table of gradient bands:
// line sequencer plus saturating per-channel colour stepping.
module copper_bands
  import copper_pkg::*;
#(
  parameter int          COORD_WIDTH = 16,
  parameter int          N_BANDS     = 4,
  parameter int          STEP_WIDTH  = 8,
  parameter logic [23:0] BACKGROUND  = 24'h000000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          hsync,
  input  logic                          vsync,
  input  logic signed [COORD_WIDTH-1:0] y,
  input  logic                          cfg_wr,
  input  logic [$clog2(N_BANDS)+1:0]    cfg_addr,
  input  logic [31:0]                   cfg_data,
  input  logic                          cfg_commit,
  output logic [23:0]                   color_rgb,
  output logic                          band_active,
  output logic                          commit_pending
);
  localparam int IDX_W = $clog2(N_BANDS);
  localparam logic [IDX_W:0] N_IDX = (IDX_W+1)'(N_BANDS);

  logic [IDX_W:0]      r_next_idx;
  logic [STEP_WIDTH-1:0] r_line_ctr;
  logic [31:0]         r_step;
  logic [23:0]         r_inc;
  logic [23:0]         r_color;
  logic                r_band_active;
  logic                r_commit_pending;

  logic                w_copy;
  logic [IDX_W:0]      w_idx;
  band_t               w_band;
  logic signed [31:0]  w_y;
  logic                w_match;
  logic                w_stepping;
  logic [31:0]         w_step_last;

  // A vsync in the same cycle restarts the list, so hsync looks at band 0
  // of the table that is being committed right now (the shadow).
  assign w_copy      = vsync && (r_commit_pending || cfg_commit);
  assign w_idx       = vsync ? '0 : r_next_idx;
  assign w_y         = 32'(y);
  assign w_match     = hsync && (w_idx < N_IDX) && w_band.enable && (w_y == w_band.start_y);
  assign w_stepping  = hsync && !vsync && r_band_active;
  assign w_step_last = (r_step == 32'd0) ? 32'd0 : r_step - 32'd1;

  copper_band_table #(
    .COORD_WIDTH (COORD_WIDTH),
    .N_BANDS     (N_BANDS),
    .STEP_WIDTH  (STEP_WIDTH),
    .BACKGROUND  (BACKGROUND)
  ) u_table (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_wr        (cfg_wr),
    .i_addr      (cfg_addr),
    .i_data      (cfg_data),
    .i_copy      (w_copy),
    .i_rd_idx    (w_idx[IDX_W-1:0]),
    .i_rd_shadow (w_copy),
    .o_band      (w_band)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_commit_pending <= 1'b0;
      r_next_idx       <= '0;
      r_color          <= BACKGROUND;
      r_band_active    <= 1'b0;
      r_line_ctr       <= '0;
    end else begin
      if (vsync)           r_commit_pending <= 1'b0;
      else if (cfg_commit) r_commit_pending <= 1'b1;

      if (vsync) begin
        r_next_idx    <= '0;
        r_color       <= BACKGROUND;
        r_band_active <= 1'b0;
        r_line_ctr    <= '0;
      end

      if (w_match) begin
        r_color       <= w_band.base;
        r_line_ctr    <= '0;
        r_next_idx    <= w_idx + (IDX_W+1)'(1);
        r_band_active <= 1'b1;
      end else if (w_stepping) begin
        if (32'(r_line_ctr) == w_step_last) begin
          r_line_ctr <= '0;
          r_color    <= rgb_step(r_color, r_inc);
        end else begin
          r_line_ctr <= r_line_ctr + STEP_WIDTH'(1);
        end
      end
    end
  end

  // Gradient parameters are only consulted while a band is active.
  always_ff @(posedge clk) begin
    if (w_match) begin
      r_inc  <= w_band.inc;
      r_step <= w_band.step;
    end
  end

  assign color_rgb      = r_color;
  assign band_active    = r_band_active;
  assign commit_pending = r_commit_pending;

endmodule

// File: tb/tb_copper_bands.sv
// Directed bench for copper_bands: vector table for the band scenarios,
// hand-written sequences for commit/reset corner cases.
module tb_copper_bands;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               hsync, vsync;
  logic signed [15:0] y;
  logic               cfg_wr;
  logic [3:0]         cfg_addr;
  logic [31:0]        cfg_data;
  logic               cfg_commit;
  logic [23:0]        color_rgb;
  logic               band_active;
  logic               commit_pending;

  int checks   = 0;
  int failures = 0;

  copper_bands #(
    .COORD_WIDTH (16),
    .N_BANDS     (4),
    .STEP_WIDTH  (8),
    .BACKGROUND  (24'h000000)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hsync          (hsync),
    .vsync          (vsync),
    .y              (y),
    .cfg_wr         (cfg_wr),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .color_rgb      (color_rgb),
    .band_active    (band_active),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vs;
    logic        hs;
    int          yy;
    logic        cm;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        chk;
    logic [23:0] exp_c;
    logic        exp_a;
    logic        exp_p;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_wr(input logic [3:0] a, input logic [31:0] d);
    vec_t v;
    v = '{vs: 1'b0, hs: 1'b0, yy: 0, cm: 1'b0, wr: 1'b1, addr: a, data: d,
          chk: 1'b0, exp_c: 24'h0, exp_a: 1'b0, exp_p: 1'b0};
    return v;
  endfunction

  function automatic vec_t mk_st(input logic vs, input logic hs, input int yy, input logic cm,
                                 input logic [23:0] c, input logic a, input logic p);
    vec_t v;
    v = '{vs: vs, hs: hs, yy: yy, cm: cm, wr: 1'b0, addr: 4'h0, data: 32'h0,
          chk: 1'b1, exp_c: c, exp_a: a, exp_p: p};
    return v;
  endfunction

  task automatic cyc(input logic vs, input logic hs, input int yy, input logic cm,
                     input logic wr, input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    vsync = vs; hsync = hs; y = 16'(yy); cfg_commit = cm;
    cfg_wr = wr; cfg_addr = a; cfg_data = d;
    @(posedge clk);
    #1;
    vsync = 1'b0; hsync = 1'b0; cfg_commit = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic check(input string nm, input logic [23:0] c, input logic a, input logic p);
    checks++;
    if (color_rgb !== c || band_active !== a || commit_pending !== p) begin
      failures++;
      $display("FAIL %s: got color=%06h active=%b pending=%b, want color=%06h active=%b pending=%b",
               nm, color_rgb, band_active, commit_pending, c, a, p);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, a, d);
  endtask

  task automatic st(input string nm, input logic vs, input logic hs, input int yy, input logic cm,
                    input logic [23:0] c, input logic ea, input logic ep);
    cyc(vs, hs, yy, cm, 1'b0, 4'h0, 32'h0);
    check(nm, c, ea, ep);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check(nm, 24'h000000, 1'b0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; hsync = 1'b0; vsync = 1'b0; y = '0;
    cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_commit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 24'h000000, 1'b0, 1'b0);
    reset_n = 1'b1;

    // Empty table: commit alone only raises pending, then nothing ever matches.
    st("commit_no_vsync", 1'b0, 1'b0, 0, 1'b1, 24'h000000, 1'b0, 1'b1);
    st("empty_vsync",     1'b1, 1'b0, 0, 1'b0, 24'h000000, 1'b0, 1'b0);
    for (int ln = 0; ln < 200; ln++)
      st($sformatf("empty_line%0d", ln), 1'b0, 1'b1, ln, 1'b0, 24'h000000, 1'b0, 1'b0);

    // Band 0 gradient, step 2
    vecs.push_back(mk_wr(4'd0, 32'd10));
    vecs.push_back(mk_wr(4'd1, 32'h0010_2030));
    vecs.push_back(mk_wr(4'd2, 32'h0001_0203));
    vecs.push_back(mk_wr(4'd3, 32'h8000_0002));
    vecs.push_back(mk_st(0, 0, 0,  1, 24'h000000, 0, 1));
    vecs.push_back(mk_st(1, 0, 0,  0, 24'h000000, 0, 0));
    vecs.push_back(mk_st(0, 1, 8,  0, 24'h000000, 0, 0));
    vecs.push_back(mk_st(0, 1, 9,  0, 24'h000000, 0, 0));
    vecs.push_back(mk_st(0, 1, 10, 0, 24'h102030, 1, 0));
    vecs.push_back(mk_st(0, 1, 11, 0, 24'h102030, 1, 0));
    vecs.push_back(mk_st(0, 1, 12, 0, 24'h112233, 1, 0));
    vecs.push_back(mk_st(0, 1, 13, 0, 24'h112233, 1, 0));
    vecs.push_back(mk_st(0, 1, 14, 0, 24'h122436, 1, 0));
    // Per-channel saturation, step 1
    vecs.push_back(mk_wr(4'd1, 32'h00FE_FE01));
    vecs.push_back(mk_wr(4'd2, 32'h0002_FFFD));
    vecs.push_back(mk_wr(4'd3, 32'h8000_0001));
    vecs.push_back(mk_st(0, 0, 0,  1, 24'h122436, 1, 1));
    vecs.push_back(mk_st(1, 0, 0,  0, 24'h000000, 0, 0));
    vecs.push_back(mk_st(0, 1, 10, 0, 24'hFEFE01, 1, 0));
    vecs.push_back(mk_st(0, 1, 11, 0, 24'hFFFD00, 1, 0));
    vecs.push_back(mk_st(0, 1, 12, 0, 24'hFFFC00, 1, 0));
    vecs.push_back(mk_st(0, 1, 13, 0, 24'hFFFB00, 1, 0));
    // Four bands, band 2 disabled terminates the list
    vecs.push_back(mk_wr(4'd0,  32'd5));
    vecs.push_back(mk_wr(4'd1,  32'h0011_2233));
    vecs.push_back(mk_wr(4'd2,  32'h0000_0000));
    vecs.push_back(mk_wr(4'd3,  32'h8000_0001));
    vecs.push_back(mk_wr(4'd4,  32'd20));
    vecs.push_back(mk_wr(4'd5,  32'h0044_5566));
    vecs.push_back(mk_wr(4'd6,  32'h0000_0000));
    vecs.push_back(mk_wr(4'd7,  32'h8000_0001));
    vecs.push_back(mk_wr(4'd8,  32'd25));
    vecs.push_back(mk_wr(4'd11, 32'h0000_0000));
    vecs.push_back(mk_wr(4'd12, 32'd30));
    vecs.push_back(mk_wr(4'd13, 32'h00AA_BBCC));
    vecs.push_back(mk_wr(4'd14, 32'h0000_0000));
    vecs.push_back(mk_wr(4'd15, 32'h8000_0001));
    vecs.push_back(mk_st(0, 0, 0,  1, 24'hFFFB00, 1, 1));
    vecs.push_back(mk_st(1, 0, 0,  0, 24'h000000, 0, 0));
    vecs.push_back(mk_st(0, 1, 4,  0, 24'h000000, 0, 0));
    vecs.push_back(mk_st(0, 1, 5,  0, 24'h112233, 1, 0));
    vecs.push_back(mk_st(0, 1, 19, 0, 24'h112233, 1, 0));
    vecs.push_back(mk_st(0, 1, 20, 0, 24'h445566, 1, 0));
    vecs.push_back(mk_st(0, 1, 25, 0, 24'h445566, 1, 0));
    vecs.push_back(mk_st(0, 1, 30, 0, 24'h445566, 1, 0));
    vecs.push_back(mk_st(0, 1, 31, 0, 24'h445566, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].vs, vecs[i].hs, vecs[i].yy, vecs[i].cm, vecs[i].wr, vecs[i].addr, vecs[i].data);
      if (vecs[i].chk)
        check($sformatf("vec%0d_y%0d", i, vecs[i].yy), vecs[i].exp_c, vecs[i].exp_a, vecs[i].exp_p);
    end

    // Shadow write without commit must not reach the active table
    wr(4'd7, 32'h0000_0000);
    wr(4'd0, 32'd10);
    wr(4'd1, 32'h0010_2030);
    wr(4'd3, 32'h8000_0001);
    st("sh_commit",      1'b0, 1'b0, 0,  1'b1, 24'h445566, 1'b1, 1'b1);
    st("sh_vsync",       1'b1, 1'b0, 0,  1'b0, 24'h000000, 1'b0, 1'b0);
    st("sh_line10",      1'b0, 1'b1, 10, 1'b0, 24'h102030, 1'b1, 1'b0);
    wr(4'd1, 32'h000A_0B0C);
    st("sh_line11",      1'b0, 1'b1, 11, 1'b0, 24'h102030, 1'b1, 1'b0);
    st("sh_vsync2",      1'b1, 1'b0, 0,  1'b0, 24'h000000, 1'b0, 1'b0);
    st("sh_nocommit10",  1'b0, 1'b1, 10, 1'b0, 24'h102030, 1'b1, 1'b0);
    st("sh_commit_a",    1'b0, 1'b0, 0,  1'b1, 24'h102030, 1'b1, 1'b1);
    st("sh_commit_b",    1'b0, 1'b0, 0,  1'b1, 24'h102030, 1'b1, 1'b1);
    st("sh_vsync3",      1'b1, 1'b0, 0,  1'b0, 24'h000000, 1'b0, 1'b0);
    st("sh_newbase10",   1'b0, 1'b1, 10, 1'b0, 24'h0A0B0C, 1'b1, 1'b0);

    // vsync + hsync + commit together load the new band 0 at once
    wr(4'd0, 32'd40);
    wr(4'd1, 32'h0055_6677);
    st("vhc_same_cycle", 1'b1, 1'b1, 40, 1'b1, 24'h556677, 1'b1, 1'b0);

    // Write coincident with the commit copy stays in the shadow
    st("wc_commit",      1'b0, 1'b0, 0,  1'b1, 24'h556677, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b1, 4'd1, 32'h0099_9999);
    check("wc_vsync_wr", 24'h000000, 1'b0, 1'b0);
    st("wc_line40",      1'b0, 1'b1, 40, 1'b0, 24'h556677, 1'b1, 1'b0);
    st("wc_commit2",     1'b0, 1'b0, 0,  1'b1, 24'h556677, 1'b1, 1'b1);
    st("wc_vsync2",      1'b1, 1'b0, 0,  1'b0, 24'h000000, 1'b0, 1'b0);
    st("wc_line40b",     1'b0, 1'b1, 40, 1'b0, 24'h999999, 1'b1, 1'b0);

    // Mid-frame reset reverts outputs and both tables
    st("rst_commit",     1'b0, 1'b0, 0,  1'b1, 24'h999999, 1'b1, 1'b1);
    do_reset("rst_mid");
    st("rst_vsync",      1'b1, 1'b0, 0,  1'b0, 24'h000000, 1'b0, 1'b0);
    st("rst_line40",     1'b0, 1'b1, 40, 1'b0, 24'h000000, 1'b0, 1'b0);
    st("rst_cm_vsync",   1'b1, 1'b0, 0,  1'b1, 24'h000000, 1'b0, 1'b0);
    st("rst_line40b",    1'b0, 1'b1, 40, 1'b0, 24'h000000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
